// File: rtl/axis_sample_tx.sv
// ADC sample to AXI-Stream bridge: offset-binary/two's-complement conversion,
// sign extension to 32 bits, and a small circular FIFO with overflow accounting.
module axis_sample_tx #(
   parameter int IN_W       = 16,
   parameter int DEPTH      = 4,
   parameter int OFFSET_BIN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [IN_W-1:0]   sample_data,
   input  logic              m_axis_tready,
   output logic              m_axis_tvalid,
   output logic [31:0]       m_axis_tdata,
   input  logic              ovf_clr,
   output logic              ovf_flag,
   output logic [15:0]       ovf_count,
   output logic [4:0]        level
);

   localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_L = 5'(DEPTH);

   logic signed [31:0] mem_p0 [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [4:0]         level_q;
   logic               full;
   logic               push;
   logic               pop;
   logic               drop;

   function automatic logic signed [31:0] conv_sample(input logic [IN_W-1:0] s);
      logic [IN_W-1:0] t;
      t = s;
      if (OFFSET_BIN != 0) t[IN_W-1] = ~t[IN_W-1];
      return {{(32-IN_W){t[IN_W-1]}}, t};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   always_comb begin
      full = (level_q == DEPTH_L);
      pop  = (level_q != 5'd0) && m_axis_tready;
      push = sample_valid && (!full || pop);
      drop = sample_valid && full && !pop;
   end

   // Stage p0: converted sample storage (data path, not reset)
   always_ff @(posedge clk) begin
      if (push) mem_p0[wr_ptr] <= conv_sample(sample_data);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= 5'd0;
         ovf_flag  <= 1'b0;
         ovf_count <= 16'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level_q <= level_q + {4'd0, push} - {4'd0, pop};
         if (ovf_clr) begin
            ovf_flag  <= 1'b0;
            ovf_count <= 16'd0;
         end else if (drop) begin
            ovf_flag  <= 1'b1;
            ovf_count <= sat_inc16(ovf_count);
         end
      end
   end

   // Outputs come straight from registered state; tready never reaches tvalid.
   always_comb begin
      level         = level_q;
      m_axis_tvalid = (level_q != 5'd0);
      m_axis_tdata  = m_axis_tvalid ? mem_p0[rd_ptr] : 32'd0;
   end

endmodule

// File: tb/tb_axis_sample_tx.sv
// Bench for axis_sample_tx: queue-based reference model, scoreboard monitor,
// directed scenarios and a randomized phase.
module tb_axis_sample_tx;

   localparam int IN_W       = 16;
   localparam int DEPTH      = 4;
   localparam int OFFSET_BIN = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sample_valid;
   logic [IN_W-1:0]   sample_data;
   logic              m_axis_tready;
   logic              m_axis_tvalid;
   logic [31:0]       m_axis_tdata;
   logic              ovf_clr;
   logic              ovf_flag;
   logic [15:0]       ovf_count;
   logic [4:0]        level;

   axis_sample_tx #(.IN_W(IN_W), .DEPTH(DEPTH), .OFFSET_BIN(OFFSET_BIN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .m_axis_tready(m_axis_tready),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tdata (m_axis_tdata),
      .ovf_clr      (ovf_clr),
      .ovf_flag     (ovf_flag),
      .ovf_count    (ovf_count),
      .level        (level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Signed value of the ADC code, computed arithmetically.
   function automatic logic [31:0] ref_conv(input logic [IN_W-1:0] s);
      longint v;
      v = longint'(s);
      if (OFFSET_BIN != 0) v = v - (longint'(1) << (IN_W-1));
      else if (v >= (longint'(1) << (IN_W-1))) v = v - (longint'(1) << IN_W);
      return v[31:0];
   endfunction

   // Reference model: contents queue, expected-beat scoreboard, overflow state.
   logic [31:0] mq[$];
   logic [31:0] sb[$];
   logic        m_flag;
   int          m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         sb.delete();
         m_flag = 1'b0;
         m_cnt  = 0;
      end else begin
         bit p_pop, p_push, p_drop;
         p_pop  = (mq.size() > 0) && m_axis_tready;
         p_push = sample_valid && ((mq.size() < DEPTH) || p_pop);
         p_drop = sample_valid && !p_push;
         if (p_pop) void'(mq.pop_front());
         if (p_push) begin
            mq.push_back(ref_conv(sample_data));
            sb.push_back(ref_conv(sample_data));
         end
         if (ovf_clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
         end else if (p_drop) begin
            m_flag = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
      end
   end

   // Monitor: mid-cycle sampling of outputs against the model.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = 32'd0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("level", 32'(level), 32'(mq.size()));
         chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() > 0));
         chk("ovf_flag", 32'(ovf_flag), 32'(m_flag));
         chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
         if (prev_stall) begin
            chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("hold_tdata", m_axis_tdata, prev_data);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
            else chk("tdata", m_axis_tdata, sb.pop_front());
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step(input logic sv, input logic [IN_W-1:0] sd, input logic rdy, input logic clr);
      sample_valid  = sv;
      sample_data   = sd;
      m_axis_tready = rdy;
      ovf_clr       = clr;
      @(posedge clk);
      #1;
   endtask

   logic [IN_W-1:0] s [6];
   logic [IN_W-1:0] e;

   initial begin
      rst_n = 1'b0;
      sample_valid = 1'b0;
      sample_data = '0;
      m_axis_tready = 1'b0;
      ovf_clr = 1'b0;
      #12;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovf_flag", 32'(ovf_flag), 32'd0);
      chk("rst_ovf_count", 32'(ovf_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic flow
      step(1, 16'h8000, 1, 0);
      chk("basic0_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("basic0_tdata", m_axis_tdata, 32'h00000000);
      step(1, 16'hFFFF, 1, 0);
      chk("basic1_tdata", m_axis_tdata, 32'h00007FFF);
      chk("basic1_level", 32'(level), 32'd1);
      step(1, 16'h0000, 1, 0);
      chk("basic2_tdata", m_axis_tdata, 32'hFFFF8000);
      chk("basic2_level", 32'(level), 32'd1);
      step(0, 0, 1, 0);
      chk("basic_empty", 32'(m_axis_tvalid), 32'd0);

      // Backpressure
      for (int k = 0; k < 4; k++) begin
         s[k] = IN_W'($urandom);
         step(1, s[k], 0, 0);
      end
      step(0, 0, 0, 0);
      chk("bp_level", 32'(level), 32'd4);
      chk("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("bp_head", m_axis_tdata, ref_conv(s[0]));
      for (int k = 0; k < 4; k++) begin
         chk("bp_order", m_axis_tdata, ref_conv(s[k]));
         step(0, 0, 1, 0);
      end
      chk("bp_drained", 32'(m_axis_tvalid), 32'd0);

      // Overflow
      for (int k = 0; k < 6; k++) begin
         s[k] = IN_W'($urandom);
         step(1, s[k], 0, 0);
      end
      step(0, 0, 0, 0);
      chk("ovf_level", 32'(level), 32'd4);
      chk("ovf_flag_set", 32'(ovf_flag), 32'd1);
      chk("ovf_count2", 32'(ovf_count), 32'd2);
      for (int k = 0; k < 4; k++) begin
         chk("ovf_order", m_axis_tdata, ref_conv(s[k]));
         step(0, 0, 1, 0);
      end
      chk("ovf_drained", 32'(m_axis_tvalid), 32'd0);

      // Full with simultaneous push and pop
      step(0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         s[k] = IN_W'($urandom);
         step(1, s[k], 0, 0);
      end
      e = IN_W'($urandom);
      step(1, e, 1, 0);
      chk("fpp_level", 32'(level), 32'd4);
      chk("fpp_no_drop", 32'(ovf_count), 32'd0);
      for (int k = 1; k < 4; k++) begin
         chk("fpp_order", m_axis_tdata, ref_conv(s[k]));
         step(0, 0, 1, 0);
      end
      chk("fpp_last", m_axis_tdata, ref_conv(e));
      step(0, 0, 1, 0);
      chk("fpp_drained", 32'(m_axis_tvalid), 32'd0);

      // Saturation and clear priority
      for (int k = 0; k < 4; k++) step(1, IN_W'($urandom), 0, 0);
      for (int k = 0; k < 65537; k++) step(1, IN_W'(k), 0, 0);
      chk("sat_count", 32'(ovf_count), 32'h0000FFFF);
      chk("sat_flag", 32'(ovf_flag), 32'd1);
      step(1, 16'h1234, 0, 1);
      chk("clr_count", 32'(ovf_count), 32'd0);
      chk("clr_flag", 32'(ovf_flag), 32'd0);
      chk("clr_level", 32'(level), 32'd4);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++)
         step(($urandom_range(0, 9) < 6), IN_W'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) == 0);
      for (int k = 0; k < DEPTH + 2; k++) step(0, 0, 1, 0);
      chk("rand_drained", 32'(m_axis_tvalid), 32'd0);

      // Async reset mid-burst
      for (int k = 0; k < 3; k++) step(1, IN_W'($urandom), 0, 0);
      sample_valid = 1'b0;
      chk("ar_pre_level", 32'(level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("ar_level", 32'(level), 32'd0);
      chk("ar_tdata", m_axis_tdata, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, 0);
         chk("ar_no_stale", 32'(m_axis_tvalid), 32'd0);
      end
      step(1, 16'h8001, 0, 0);
      chk("ar_new_valid", 32'(m_axis_tvalid), 32'd1);
      chk("ar_new_data", m_axis_tdata, 32'h00000001);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
